node_skid_fifo: RTL and testbench

Receiving stage that sits directly downstream of a node whose ready input is registered for one or more cycles. Because that upstream node decides to fire using a delayed copy of our ready, beats can keep arriving for several cycles after we drop ready. This block absorbs those in-flight beats in a small FIFO so none are lost, and presents a standard zero-latency valid/ready master port to the next stage. It also reports occupancy, and raises a sticky error if upstream violates the ready contract.

---
 rtl/node_pkg.sv | 11 +
 rtl/node_skid_fifo_if.sv | 25 ++
 rtl/node_fifo_mem.sv | 29 ++
 rtl/node_skid_fifo.sv | 100 ++++++++++
 tb/tb_node_skid_fifo.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/node_pkg.sv
// Shared definitions for node pipeline stages.
package node_pkg;

  localparam int unsigned NODE_READY_LAT_DEFAULT = 1;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned node_count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/node_skid_fifo_if.sv
// Upstream/downstream handshake bundle of the skid FIFO stage.
interface node_skid_fifo_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] data_in;
  logic             valid_up_in;
  logic             ready_up_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_down_out;
  logic             ready_down_in;

  // The FIFO stage itself.
  modport slave (
    input  data_in, valid_up_in, ready_down_in,
    output data_out, valid_down_out, ready_up_out
  );

  // Whoever drives the stage (upstream producer plus downstream consumer).
  modport master (
    output data_in, valid_up_in, ready_down_in,
    input  data_out, valid_down_out, ready_up_out
  );

endinterface

// File: rtl/node_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, async read.
module node_fifo_mem #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/node_skid_fifo.sv
// Receiving stage for an upstream node that sees our ready READY_LAT cycles
// late: in-flight beats land in a small FIFO, downstream gets plain valid/ready.
module node_skid_fifo
  import node_pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned READY_LAT = NODE_READY_LAT_DEFAULT,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = node_count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  node_skid_fifo_if.slave   bus,
  output logic [CW-1:0]     count,
  output logic              overflow_err
);

  // Reject configurations that cannot absorb the in-flight beats.
  if (DEPTH < READY_LAT + 2) begin : g_depth_chk
    $error("node_skid_fifo: DEPTH must be >= READY_LAT+2");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_pow2_chk
    $error("node_skid_fifo: DEPTH must be a power of two");
  end
  if (READY_LAT > 3) begin : g_lat_chk
    $error("node_skid_fifo: READY_LAT must be 0..3");
  end

  logic          grant;
  logic          push;
  logic          pop;
  logic          full;
  logic          push_acc;
  logic          drop;
  logic          ready_next;
  logic [CW-1:0] count_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Local copy of the ready delay line upstream applies; its oldest bit is
  // the ready value upstream is acting on this cycle.
  if (READY_LAT == 0) begin : g_no_sh
    assign grant = bus.ready_up_out;
  end else begin : g_sh
    logic [READY_LAT-1:0] rdy_sh;

    // Shift our registered ready into the delay line.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_sh <= '0;
      else     rdy_sh <= READY_LAT'({rdy_sh, bus.ready_up_out});
    end

    assign grant = rdy_sh[READY_LAT-1];
  end

  // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    full       = (count == CW'(DEPTH));
    push       = bus.valid_up_in & grant;
    pop        = bus.valid_down_out & bus.ready_down_in;
    push_acc   = push & (~full | pop);
    drop       = push & full & ~pop;
    count_next = count + CW'(push_acc) - CW'(pop);
    ready_next = ((32'(count_next) + READY_LAT + 32'd1) <= DEPTH);
  end

  // Pointers, occupancy, registered ready/valid and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.ready_up_out   <= 1'b0;
      bus.valid_down_out <= 1'b0;
      overflow_err       <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr + AW'(push_acc);
      rd_ptr             <= rd_ptr + AW'(pop);
      count              <= count_next;
      bus.ready_up_out   <= ready_next;
      bus.valid_down_out <= (count_next != '0);
      if (drop) overflow_err <= 1'b1;
    end
  end

  node_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

endmodule

// File: tb/tb_node_skid_fifo.sv
// Scoreboard bench for node_skid_fifo (DEPTH=4, READY_LAT=1).
module tb_node_skid_fifo;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned READY_LAT = 1;
  localparam int unsigned CW        = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] count;
  logic          overflow_err;

  node_skid_fifo_if #(.WIDTH(WIDTH)) bus ();

  node_skid_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .READY_LAT (READY_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] sb[$];
  logic             exp_ready;
  logic             exp_grant;
  logic             exp_err;
  logic             acc;
  logic             popped;
  logic [WIDTH-1:0] nxt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(sb.size()));
    check("valid", 32'(bus.valid_down_out), 32'(sb.size() != 0));
    check("ready", 32'(bus.ready_up_out), 32'(exp_ready));
    check("err", 32'(overflow_err), 32'(exp_err));
    if (sb.size() != 0) check("head", bus.data_out, sb[0]);
  endtask

  // One clock of stimulus; the model applies the clock edge effects.
  task automatic cycle(input logic vin, input logic [WIDTH-1:0] din, input logic rd,
                       input logic force_grant);
    logic g, push, pop, full;
    bus.valid_up_in   = vin;
    bus.data_in       = din;
    bus.ready_down_in = rd;
    if (force_grant) force dut.grant = 1'b1;
    g    = force_grant | exp_grant;
    full = (sb.size() == int'(DEPTH));
    push = vin & g;
    pop  = (sb.size() != 0) & rd;
    acc  = 1'b0;
    popped = pop;
    if (pop) begin
      check("pop_valid", 32'(bus.valid_down_out), 32'd1);
      check("pop_data", bus.data_out, sb.pop_front());
    end
    if (push) begin
      if (!full || pop) begin
        sb.push_back(din);
        acc = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (force_grant) release dut.grant;
    exp_grant = exp_ready;
    exp_ready = ((32'(sb.size()) + READY_LAT + 32'd1) <= DEPTH);
    check_state();
  endtask

  task automatic run(input int n, input logic vin, input logic rd);
    for (int i = 0; i < n; i++) begin
      cycle(vin, nxt, rd, 1'b0);
      if (acc) nxt++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(count), 32'd0);
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.valid_up_in   = 1'b0;
    bus.data_in       = '0;
    bus.ready_down_in = 1'b0;
    sb.delete();
    exp_ready = 1'b0;
    exp_grant = 1'b0;
    exp_err   = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(bus.valid_down_out), 32'd0);
    check("rst_ready", 32'(bus.ready_up_out), 32'd0);
    check("rst_data", bus.data_out, 32'd0);
    @(posedge clk);
    #1;
    check_state();
    check("rst_data_edge", bus.data_out, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops;
    int maxc;

    // Reset release and first-beat latency.
    do_reset();
    nxt = 32'hA0;
    run(1, 1'b1, 1'b0);
    check("lat_ready_c1", 32'(bus.ready_up_out), 32'd1);
    run(1, 1'b1, 1'b0);
    check("lat_count_c2", 32'(count), 32'd0);
    run(1, 1'b1, 1'b0);
    check("lat_valid_c3", 32'(bus.valid_down_out), 32'd1);
    check("lat_data_c3", bus.data_out, 32'hA0);
    run(3, 1'b1, 1'b1);
    drain();

    // Downstream stalled: exactly DEPTH beats absorbed.
    do_reset();
    nxt = 32'h10;
    run(8, 1'b1, 1'b0);
    check("stall_count", 32'(count), 32'd4);
    check("stall_err", 32'(overflow_err), 32'd0);
    check("stall_ready", 32'(bus.ready_up_out), 32'd0);
    check("stall_last", 32'(sb[3]), 32'h13);
    drain();

    // Continuous flow: one pop per cycle, shallow occupancy.
    do_reset();
    nxt = 32'h100;
    run(4, 1'b1, 1'b1);
    pops = 0;
    maxc = 0;
    for (int i = 0; i < 12; i++) begin
      run(1, 1'b1, 1'b1);
      if (popped) pops++;
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("thru_pops", 32'(pops), 32'd12);
    check("thru_maxcnt_le2", 32'(maxc <= 2), 32'd1);
    drain();

    // Rogue upstream: granted beat while full, no pop.
    do_reset();
    nxt = 32'h40;
    run(6, 1'b1, 1'b0);
    check("rogue_pre_count", 32'(count), 32'd4);
    cycle(1'b1, 32'hFF, 1'b0, 1'b1);
    check("rogue_err", 32'(overflow_err), 32'd1);
    check("rogue_count", 32'(count), 32'd4);
    run(3, 1'b0, 1'b0);
    drain();
    check("rogue_err_sticky", 32'(overflow_err), 32'd1);

    // Full with simultaneous push and pop.
    do_reset();
    nxt = 32'h50;
    run(6, 1'b1, 1'b0);
    cycle(1'b1, nxt, 1'b1, 1'b1);
    if (acc) nxt++;
    check("fullpp_count", 32'(count), 32'd4);
    check("fullpp_err", 32'(overflow_err), 32'd0);
    check("fullpp_head", bus.data_out, 32'h51);
    drain();

    // Reset with three entries stored, then resume.
    do_reset();
    nxt = 32'h60;
    for (int i = 0; i < 10 && sb.size() != 3; i++) run(1, 1'b1, 1'b0);
    check("mid_count3", 32'(count), 32'd3);
    do_reset();
    nxt = 32'h70;
    run(6, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
